// File: rtl/dpic_sram_arbiter.sv
`timescale 1ns/1ps
// Two-port (LSU = port 0, IFU = port 1) arbiter/sequencer in front of the single-port DPI-C SRAM.
// One access in flight at a time; define DPIC_SRAM_ARB_RR_EN for round-robin, else port 0 has fixed priority.
module dpic_sram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req_valid,
  output logic                    m0_req_ready,
  input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
  input  logic [DATA_WIDTH/8-1:0] m0_req_wmask,
  input  logic [1:0]              m0_req_size,
  input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
  output logic                    m0_resp_valid,
  input  logic                    m0_resp_ready,
  output logic [DATA_WIDTH-1:0]   m0_resp_rdata,
  input  logic                    m1_req_valid,
  output logic                    m1_req_ready,
  input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
  input  logic [DATA_WIDTH/8-1:0] m1_req_wmask,
  input  logic [1:0]              m1_req_size,
  input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
  output logic                    m1_resp_valid,
  input  logic                    m1_resp_ready,
  output logic [DATA_WIDTH-1:0]   m1_resp_rdata,
  output logic                    sram_en,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH/8-1:0] sram_wmask,
  output logic [1:0]              sram_size,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH-1:0]   sram_rdata
);

  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [MW-1:0]         r_wmask;
  logic [1:0]            r_size;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_accept;
  logic                  w_resp_done;
  logic [DATA_WIDTH-1:0] w_rdata;

`ifdef DPIC_SRAM_ARB_RR_EN
  logic r_rr_ptr;

  // Pointer hands the next tie to the port that did not just win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_accept) begin
      r_rr_ptr <= ~w_gnt1;
    end
  end

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_IDLE && !rst) begin
      if (r_rr_ptr) begin
        w_gnt1 = m1_req_valid;
        w_gnt0 = m0_req_valid & ~m1_req_valid;
      end else begin
        w_gnt0 = m0_req_valid;
        w_gnt1 = m1_req_valid & ~m0_req_valid;
      end
    end
  end
`else
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_IDLE && !rst) begin
      w_gnt0 = m0_req_valid;
      w_gnt1 = m1_req_valid & ~m0_req_valid;
    end
  end
`endif

  assign w_accept    = w_gnt0 | w_gnt1;
  assign w_resp_done = (r_state == S_RESP) && (r_owner ? m1_resp_ready : m0_resp_ready);
  assign w_rdata     = (r_wmask == '0) ? sram_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fields are captured only on the accepting edge; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_wmask <= '0;
      r_size  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_owner <= w_gnt1;
      r_addr  <= w_gnt1 ? m1_req_addr  : m0_req_addr;
      r_wmask <= w_gnt1 ? m1_req_wmask : m0_req_wmask;
      r_size  <= w_gnt1 ? m1_req_size  : m0_req_size;
      r_wdata <= w_gnt1 ? m1_req_wdata : m0_req_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP:  if (w_resp_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    m0_req_ready  = w_gnt0;
    m1_req_ready  = w_gnt1;
    m0_resp_valid = 1'b0;
    m1_resp_valid = 1'b0;
    m0_resp_rdata = '0;
    m1_resp_rdata = '0;
    sram_en       = 1'b0;
    sram_addr     = '0;
    sram_wmask    = '0;
    sram_size     = '0;
    sram_wdata    = '0;
    case (r_state)
      S_ISSUE: begin
        sram_en    = 1'b1;
        sram_addr  = r_addr;
        sram_wmask = r_wmask;
        sram_size  = r_size;
        sram_wdata = r_wdata;
      end
      S_RESP: begin
        if (r_owner) begin
          m1_resp_valid = 1'b1;
          m1_resp_rdata = w_rdata;
        end else begin
          m0_resp_valid = 1'b1;
          m0_resp_rdata = w_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dpic_sram_arbiter.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for dpic_sram_arbiter; honours DPIC_SRAM_ARB_RR_EN for the expected arbitration.
module tb_dpic_sram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
`ifdef DPIC_SRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [AW-1:0] req_addr  [2];
  logic [MW-1:0] req_wmask [2];
  logic [1:0]    req_size  [2];
  logic [DW-1:0] req_wdata [2];
  logic [1:0]    resp_valid;
  logic [1:0]    resp_ready;
  logic [DW-1:0] resp_rdata [2];
  logic          sram_en;
  logic [AW-1:0] sram_addr;
  logic [MW-1:0] sram_wmask;
  logic [1:0]    sram_size;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  always #5 clk = ~clk;

  dpic_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(req_valid[0]), .m0_req_ready(req_ready[0]), .m0_req_addr(req_addr[0]),
    .m0_req_wmask(req_wmask[0]), .m0_req_size(req_size[0]), .m0_req_wdata(req_wdata[0]),
    .m0_resp_valid(resp_valid[0]), .m0_resp_ready(resp_ready[0]), .m0_resp_rdata(resp_rdata[0]),
    .m1_req_valid(req_valid[1]), .m1_req_ready(req_ready[1]), .m1_req_addr(req_addr[1]),
    .m1_req_wmask(req_wmask[1]), .m1_req_size(req_size[1]), .m1_req_wdata(req_wdata[1]),
    .m1_resp_valid(resp_valid[1]), .m1_resp_ready(resp_ready[1]), .m1_resp_rdata(resp_rdata[1]),
    .sram_en(sram_en), .sram_addr(sram_addr), .sram_wmask(sram_wmask), .sram_size(sram_size),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // SRAM stand-in: registered read one cycle after sram_en, masked byte writes.
  logic [DW-1:0] sram_mem [logic [AW-1:0]];
  always @(posedge clk) begin
    if (sram_en) begin
      logic [DW-1:0] w;
      w = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : init_word(sram_addr);
      sram_rdata <= w;
      if (sram_wmask != '0) begin
        for (int b = 0; b < MW; b++)
          if (sram_wmask[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
        sram_mem[sram_addr] = w;
      end
    end
  end

  // Reference model: flat memory plus "one transaction outstanding" timing.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  int            grant_log [$];
  logic [DW-1:0] last_rdata [2];
  bit            m_busy = 1'b0;
  int            m_age = 0;
  int            m_owner = 0;
  bit            m_fav = 1'b0;
  logic [AW-1:0] e_addr;
  logic [MW-1:0] e_wmask;
  logic [1:0]    e_size;
  logic [DW-1:0] e_wdata;
  logic          er0, er1, erv;
  logic [DW-1:0] e_data;

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sram_mem[a] = d;
    ref_mem[a]  = d;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_fav  = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (m_busy) m_age++;
      if (m_busy && m_age == 1) begin
        chk("issue_en",    64'(sram_en),    64'd1);
        chk("issue_addr",  64'(sram_addr),  64'(e_addr));
        chk("issue_wmask", 64'(sram_wmask), 64'(e_wmask));
        chk("issue_size",  64'(sram_size),  64'(e_size));
        chk("issue_wdata", 64'(sram_wdata), 64'(e_wdata));
      end else begin
        chk("sram_quiet", 64'(sram_en | (|sram_addr) | (|sram_wmask) | (|sram_size) | (|sram_wdata)), 64'd0);
      end
      er0 = 1'b0;
      er1 = 1'b0;
      if (!m_busy) begin
        if (req_valid[0] && req_valid[1]) begin
          if (RR_EN && m_fav) er1 = 1'b1;
          else er0 = 1'b1;
        end else begin
          er0 = req_valid[0];
          er1 = req_valid[1];
        end
      end
      chk("req_ready0", 64'(req_ready[0]), 64'(er0));
      chk("req_ready1", 64'(req_ready[1]), 64'(er1));
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && req_ready[p]) grant_log.push_back(p);
        erv = m_busy && (m_age >= 2) && (m_owner == p);
        chk($sformatf("resp_valid%0d", p), 64'(resp_valid[p]), 64'(erv));
        if (resp_valid[p] && erv) begin
          if ((p == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            chk($sformatf("resp_unexpected%0d", p), 64'd1, 64'd0);
          end else begin
            e_data = (p == 0) ? exp_q0[0] : exp_q1[0];
            chk($sformatf("resp_rdata%0d", p), 64'(resp_rdata[p]), 64'(e_data));
            if (resp_ready[p]) begin
              last_rdata[p] = resp_rdata[p];
              if (p == 0) void'(exp_q0.pop_front());
              else void'(exp_q1.pop_front());
              m_busy = 1'b0;
            end
          end
        end
      end
      if (er0 || er1) begin
        int w;
        w       = er1 ? 1 : 0;
        m_busy  = 1'b1;
        m_age   = 0;
        m_owner = w;
        m_fav   = (w == 0);
        e_addr  = req_addr[w];
        e_wmask = req_wmask[w];
        e_size  = req_size[w];
        e_wdata = req_wdata[w];
        e_data  = ref_mem.exists(e_addr) ? ref_mem[e_addr] : init_word(e_addr);
        if (e_wmask != '0) begin
          for (int b = 0; b < MW; b++)
            if (e_wmask[b]) e_data[8*b +: 8] = e_wdata[8*b +: 8];
          ref_mem[e_addr] = e_data;
          e_data = '0;
        end
        if (w == 0) exp_q0.push_back(e_data);
        else exp_q1.push_back(e_data);
      end
    end
  end

  task automatic drive(input int p, input logic [AW-1:0] a, input logic [MW-1:0] wm,
                       input logic [1:0] sz, input logic [DW-1:0] wd);
    bit done;
    done = 1'b0;
    req_addr[p]  = a;
    req_wmask[p] = wm;
    req_size[p]  = sz;
    req_wdata[p] = wd;
    req_valid[p] = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (req_ready[p]) done = 1'b1;
    end
    chk($sformatf("req_accept%0d", p), 64'(done), 64'd1);
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
    req_addr[p]  = $urandom;
    req_wmask[p] = MW'($urandom);
    req_size[p]  = 2'($urandom);
    req_wdata[p] = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && m_busy; i++) @(posedge clk);
    chk("idle_reached", 64'(m_busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return 32'h8000_0000 + 32'(4 * $urandom_range(0, 7));
  endfunction

  function automatic logic [MW-1:0] rnd_mask();
    return ($urandom_range(0, 1) == 1) ? MW'($urandom_range(1, 15)) : '0;
  endfunction

  bit stop_rr;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    for (int p = 0; p < 2; p++) begin
      req_addr[p] = '0; req_wmask[p] = '0; req_size[p] = '0; req_wdata[p] = '0;
      last_rdata[p] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready",  64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_sram_en",    64'(sram_en), 64'd0);
    chk("rst_sram_bus",   64'((|sram_addr) | (|sram_wmask) | (|sram_size) | (|sram_wdata)), 64'd0);
    chk("rst_rdata",      64'((|resp_rdata[0]) | (|resp_rdata[1])), 64'd0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_ready = 2'b11;

    // Single read, write ack, read-back
    preload(32'h8000_0000, 32'hDEAD_BEEF);
    drive(0, 32'h8000_0000, 4'h0, 2'd2, 32'h0);
    wait_idle();
    chk("read_deadbeef", 64'(last_rdata[0]), 64'hDEAD_BEEF);
    drive(1, 32'h8000_0010, 4'hF, 2'd2, 32'h1234_5678);
    wait_idle();
    chk("write_ack_zero", 64'(last_rdata[1]), 64'd0);
    drive(0, 32'h8000_0010, 4'h0, 2'd2, 32'h0);
    wait_idle();
    chk("readback", 64'(last_rdata[0]), 64'h1234_5678);

    // Response backpressure with a competing port-1 request
    resp_ready[0] = 1'b0;
    drive(0, 32'h8000_0000, 4'h0, 2'd2, 32'h0);
    fork
      drive(1, 32'h8000_0004, 4'h0, 2'd2, 32'h0);
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("bp_valid_held", 64'(resp_valid[0]), 64'd1);
        chk("bp_rdata_held", 64'(resp_rdata[0]), 64'hDEAD_BEEF);
        resp_ready[0] = 1'b1;
      end
    join
    wait_idle();

    // Tie arbitration from a fresh reset
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++) drive(0, rnd_addr(), 4'h0, 2'd2, 32'h0);
      for (int i = 0; i < 4; i++) drive(1, rnd_addr(), 4'h0, 2'd2, 32'h0);
    join
    wait_idle();
    chk("tie_count", 64'(grant_log.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk($sformatf("tie_grant%0d", i), 64'(grant_log[i]), RR_EN ? 64'(i % 2) : 64'd0);

    // Asynchronous reset during ISSUE
    drive(0, 32'h8000_0020, 4'h0, 2'd2, 32'h0);
    chk("issue_before_rst", 64'(sram_en), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_sram_en",    64'(sram_en), 64'd0);
    chk("arst_sram_bus",   64'((|sram_addr) | (|sram_wmask) | (|sram_size) | (|sram_wdata)), 64'd0);
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    chk("arst_req_ready",  64'(req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 32'h8000_0010, 4'h0, 2'd2, 32'h0);
    wait_idle();
    chk("post_rst_read", 64'(last_rdata[1]), 64'h1234_5678);

    // Randomized traffic from both ports with random response backpressure
    stop_rr = 1'b0;
    fork
      begin
        fork
          for (int i = 0; i < 30; i++) begin
            int k;
            k = $urandom_range(0, 5);
            if (k > 0) begin repeat (k) @(posedge clk); #1; end
            drive(0, rnd_addr(), rnd_mask(), 2'($urandom_range(0, 2)), $urandom);
          end
          for (int i = 0; i < 30; i++) begin
            int k;
            k = $urandom_range(0, 5);
            if (k > 0) begin repeat (k) @(posedge clk); #1; end
            drive(1, rnd_addr(), rnd_mask(), 2'($urandom_range(0, 2)), $urandom);
          end
        join
        stop_rr = 1'b1;
      end
      while (!stop_rr) begin
        @(posedge clk);
        #1;
        resp_ready = 2'($urandom);
      end
    join
    resp_ready = 2'b11;
    wait_idle();
    chk("drain_q0", 64'(exp_q0.size()), 64'd0);
    chk("drain_q1", 64'(exp_q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dpic_sram_arbiter.md
# dpic_sram_arbiter

Two-requester arbiter and sequencer in front of the single-port DPI-C backed simulation SRAM. It accepts read/write requests from port 0 (data bus) and port 1 (instruction fetch) through valid/ready handshakes and issues exactly one SRAM access at a time. It returns the read data or write acknowledge to the winning requester through a response handshake with backpressure. It sits between the core's LSU/IFU bus masters and the SRAM model in the simulation top.

## Interface
- ADDR_WIDTH, 32, address width, passed through to the SRAM
- DATA_WIDTH, 32, data width; the write mask is DATA_WIDTH/8 bits
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- mN_req_valid  in  1  request valid, N in {0,1}
- mN_req_ready  out  1  request accepted this cycle when valid is also high
- mN_req_addr  in  ADDR_WIDTH  byte address
- mN_req_wmask  in  DATA_WIDTH/8  byte write mask; all-zero means read
- mN_req_size  in  2  access size code: 0 = byte, 1 = half, 2 = word
- mN_req_wdata  in  DATA_WIDTH  write data
- mN_resp_valid  out  1  response valid
- mN_resp_ready  in  1  requester accepts the response
- mN_resp_rdata  out  DATA_WIDTH  read data; 0 for writes
- sram_en  out  1  SRAM access strobe
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wmask  out  DATA_WIDTH/8  SRAM write mask
- sram_size  out  2  SRAM access size
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM registered read data, valid one cycle after sram_en

## Operation
- FSM states:
  - IDLE: mN_req_ready = 1 only for the port selected by the arbiter, and only when that port's req_valid is high. A handshake latches addr, wmask, size and wdata, plus the owner id, into a request register. Next state is ISSUE.
  - ISSUE: sram_en = 1 for exactly one cycle, driven from the request register. Next state is RESP.
  - RESP: the owner's mN_resp_valid = 1. mN_resp_rdata = sram_rdata if the latched wmask is zero, else 0. Hold until the owner's resp_ready = 1, then go to IDLE.
- The non-owner port never sees req_ready or resp_valid while a transaction is outstanding.
- Outside ISSUE, all sram_* outputs are 0. sram_rdata is only sampled in RESP, and the SRAM is not re-enabled before RESP exits, so sram_rdata stays stable for the whole RESP state.
- Request fields are sampled only at the handshake. Changes to them afterwards have no effect.
- Widths are passed through unchanged; the arbiter never modifies address, mask or data.

## Timing
- Reset values: state = IDLE, owner = 0, request register = 0, round-robin pointer = port 0, all outputs 0.
- Latency: handshake in cycle T, sram_en in T+1, resp_valid in T+2. Minimum spacing between accepts is 3 cycles.
- resp_valid stays high until resp_ready. A resp_ready that is high in the same cycle resp_valid first rises completes the transaction; the next accept happens no earlier than the following cycle.
- Simultaneous valid requests from both ports in IDLE: exactly one port gets ready, per the arbitration rule in Configuration.
- Reset asserted mid-transaction: immediately returns to IDLE and drops sram_en and resp_valid asynchronously. The in-flight transaction is discarded with no response.

## Configuration
- DPIC_SRAM_ARB_RR_EN defined: round-robin arbitration. The pointer moves to the other port after each accept. On a tie, the port at the pointer wins.
- DPIC_SRAM_ARB_RR_EN not defined: fixed priority. Port 0 always wins a tie, and port 1 can starve under continuous port 0 traffic.

## Test plan
- Single read: m0 addr 0x80000000, wmask 0, size 2, with the model returning 0xDEADBEEF. Expect sram_en at T+1 with the same address, m0_resp_valid at T+2 with rdata 0xDEADBEEF, and return to IDLE after resp_ready.
- Write acknowledge: m1 wmask 0xF, wdata 0x12345678 at 0x80000010. Expect sram_wmask 0xF, m1_resp_rdata 0, and a subsequent read of 0x80000010 returning 0x12345678.
- Tie: both ports valid every cycle for 4 transactions. With RR_EN, grants go 0,1,0,1. Without it, grants go 0,0,0,0.
- Backpressure: hold m0_resp_ready low for 5 cycles. Expect resp_valid and rdata held stable, no further sram_en, and m1_req_ready held at 0 throughout.
- Async reset asserted during ISSUE: sram_en and all outputs drop to 0 without waiting for a clock edge. After release, a fresh m1 read completes in 2 cycles.
